// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, incrementer, jump/call/return resolution.
// Define PC_SEQUENCER_RAS_EN to build the return-address stack and its sticky flags.
module pc_sequencer #(
  parameter int              WIDTH           = 32,
  parameter int              INC             = 4,
  parameter logic [WIDTH-1:0] RESET_PC       = '0,
  parameter int              RAS_DEPTH       = 4,
  parameter int              STAGE_WIDTH     = 3,
  parameter int              STAGE_PC_UPDATE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [STAGE_WIDTH-1:0] stage,
  input  logic [2:0]             mode,
  input  logic [WIDTH-1:0]       jump_condition,
  input  logic [WIDTH-1:0]       jump_address,
  input  logic                   stall,
  input  logic                   flush,
  output logic [WIDTH-1:0]       pc,
  output logic [WIDTH-1:0]       next_pc,
  output logic                   pc_en,
  output logic                   redirect,
  output logic                   ras_overflow,
  output logic                   ras_underflow
);

  localparam logic [2:0] M_SEQ   = 3'd0;
  localparam logic [2:0] M_JCOND = 3'd1;
  localparam logic [2:0] M_JUMP  = 3'd2;
  localparam logic [2:0] M_CALL  = 3'd3;
  localparam logic [2:0] M_RET   = 3'd4;

  logic [WIDTH-1:0] pc_reg;
  logic             redirect_reg;
  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] next_pc_c;
  logic             commit;
  logic             non_seq;
  logic             push;
  logic             pop;
  logic             redirect_next;

  assign seq    = pc_reg + WIDTH'(INC);
  assign commit = (stage == STAGE_WIDTH'(STAGE_PC_UPDATE)) && !stall;

`ifdef PC_SEQUENCER_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] wp_reg;
  logic [PTR_W:0]   count_reg;
  logic             overflow_reg;
  logic             underflow_reg;
  logic [PTR_W-1:0] top_ptr;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;

  // wp points at the next free slot, so the top lives one entry below it
  assign top_ptr   = wp_reg - PTR_W'(1);
  assign ras_top   = ras_mem[top_ptr];
  assign ras_empty = (count_reg == '0);
  assign ras_full  = (count_reg == (PTR_W+1)'(RAS_DEPTH));
`endif

  always_comb begin
    next_pc_c = seq;
    non_seq   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (mode)
      M_JCOND: begin
        if (jump_condition == WIDTH'(1)) next_pc_c = jump_address;
      end
      M_JUMP: begin
        next_pc_c = jump_address;
        non_seq   = 1'b1;
      end
      M_CALL: begin
        next_pc_c = jump_address;
        non_seq   = 1'b1;
`ifdef PC_SEQUENCER_RAS_EN
        push      = 1'b1;
`endif
      end
      M_RET: begin
`ifdef PC_SEQUENCER_RAS_EN
        pop = 1'b1;
        if (!ras_empty) begin
          next_pc_c = ras_top;
          non_seq   = 1'b1;
        end
`endif
      end
      default: next_pc_c = seq;
    endcase
    redirect_next = commit && ((next_pc_c != seq) || non_seq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC;
      redirect_reg <= 1'b0;
    end else begin
      if (commit) pc_reg <= next_pc_c;
      redirect_reg <= redirect_next;
    end
  end

`ifdef PC_SEQUENCER_RAS_EN
  // Flush wins over a same-cycle push/pop; stall does not block flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_reg        <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (commit) begin
      if (push) begin
        wp_reg <= wp_reg + PTR_W'(1);
        if (ras_full) overflow_reg <= 1'b1;
        else          count_reg    <= count_reg + (PTR_W+1)'(1);
      end else if (pop) begin
        if (ras_empty) begin
          underflow_reg <= 1'b1;
        end else begin
          wp_reg    <= top_ptr;
          count_reg <= count_reg - (PTR_W+1)'(1);
        end
      end
    end
  end

  // Storage needs no reset; a full stack overwrites its oldest slot as wp wraps.
  always_ff @(posedge clk) begin
    if (commit && push && !flush) ras_mem[wp_reg] <= seq;
  end

  assign ras_overflow  = overflow_reg;
  assign ras_underflow = underflow_reg;
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = flush | push | pop;
  assign ras_overflow      = 1'b0;
  assign ras_underflow     = 1'b0;
`endif

  assign pc       = pc_reg;
  assign redirect = redirect_reg;
  assign next_pc  = next_pc_c;
  assign pc_en    = commit;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts every cycle,
// a negedge monitor pops and compares. Model follows PC_SEQUENCER_RAS_EN like the design.
module tb_pc_sequencer;

  localparam int          W     = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [2:0]  PCU   = 3'd2;
  localparam logic [2:0]  IDLE  = 3'd0;
`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    stage = IDLE;
  logic [2:0]    mode = 3'd0;
  logic [W-1:0]  jump_condition = '0;
  logic [W-1:0]  jump_address = '0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  pc;
  logic [W-1:0]  next_pc;
  logic          pc_en;
  logic          redirect;
  logic          ras_overflow;
  logic          ras_underflow;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH(W), .INC(4), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH),
    .STAGE_WIDTH(3), .STAGE_PC_UPDATE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stage(stage), .mode(mode),
    .jump_condition(jump_condition), .jump_address(jump_address),
    .stall(stall), .flush(flush), .pc(pc), .next_pc(next_pc), .pc_en(pc_en),
    .redirect(redirect), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pc_en;
    logic        redirect;
    logic        ovf;
    logic        udf;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  logic [31:0] m_pc;
  logic        m_redir, m_ovf, m_udf;
  logic [31:0] m_stack[$];

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
  endtask

  // monitor: pops one prediction per cycle and compares
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("next_pc", next_pc, e.next_pc);
        check("pc_en", {31'd0, pc_en}, {31'd0, e.pc_en});
        check("redirect", {31'd0, redirect}, {31'd0, e.redirect});
        check("ras_overflow", {31'd0, ras_overflow}, {31'd0, e.ovf});
        check("ras_underflow", {31'd0, ras_underflow}, {31'd0, e.udf});
        if (e.pc_en)
          $display("commit pc=0x%08h next_pc=0x%08h redirect=%0b ovf=%0b udf=%0b",
                   pc, next_pc, redirect, ras_overflow, ras_underflow);
      end
    end
  end

  task automatic drive(input logic r, input logic [2:0] st, input logic [2:0] md,
                       input logic [31:0] cond, input logic [31:0] addr,
                       input logic stl, input logic fl);
    logic [31:0] seqv, nxt;
    logic        com, nonseq, do_push, do_pop;
    exp_t        e;
    @(posedge clk);
    #1;
    rst_n = r; stage = st; mode = md; jump_condition = cond;
    jump_address = addr; stall = stl; flush = fl;
    if (!r) begin
      m_pc = RST_PC; m_redir = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      m_stack.delete();
    end
    com     = (st == PCU) && !stl;
    seqv    = m_pc + 32'd4;
    nxt     = seqv;
    nonseq  = 1'b0;
    do_push = 1'b0;
    do_pop  = 1'b0;
    case (md)
      3'd1: if (cond == 32'd1) nxt = addr;
      3'd2: begin nxt = addr; nonseq = 1'b1; end
      3'd3: begin nxt = addr; nonseq = 1'b1; do_push = RAS_EN; end
      3'd4: if (RAS_EN) begin
              do_pop = 1'b1;
              if (m_stack.size() > 0) begin nxt = m_stack[$]; nonseq = 1'b1; end
            end
      default: nxt = seqv;
    endcase
    e.pc = m_pc; e.next_pc = nxt; e.pc_en = com;
    e.redirect = m_redir; e.ovf = m_ovf; e.udf = m_udf;
    exp_q.push_back(e);
    if (r) begin
      if (com) m_pc = nxt;
      m_redir = com && ((nxt != seqv) || nonseq);
      if (RAS_EN && fl) begin
        m_stack.delete(); m_ovf = 1'b0; m_udf = 1'b0;
      end else if (com && do_push) begin
        m_stack.push_back(seqv);
        if (m_stack.size() > DEPTH) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
      end else if (com && do_pop) begin
        if (m_stack.size() == 0) m_udf = 1'b1;
        else void'(m_stack.pop_back());
      end
    end
  endtask

  task automatic step(input logic [2:0] md, input logic [31:0] cond, input logic [31:0] addr);
    drive(1'b1, PCU, md, cond, addr, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic fl);
    drive(1'b1, IDLE, 3'd0, 32'd0, 32'd0, 1'b0, fl);
  endtask

  initial begin
    logic [31:0] conds [5];
    logic [31:0] c;
    int          sel;
    m_pc = RST_PC; m_redir = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    conds[0] = 32'd0; conds[1] = 32'd1; conds[2] = 32'd3;
    conds[3] = 32'h8000_0001; conds[4] = 32'd1;

    drive(1'b0, IDLE, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b0, IDLE, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle(1'b0);
    // sequential commits held in PC_UPDATE
    repeat (3) step(3'd0, 32'd0, 32'd0);
    idle(1'b0);
    // conditional jump taken / not taken
    step(3'd2, 32'd0, 32'h10);
    step(3'd1, 32'd1, 32'h100);
    step(3'd2, 32'd0, 32'h10);
    step(3'd1, 32'd3, 32'h100);
    step(3'd1, 32'h8000_0001, 32'h100);
    idle(1'b0);
    // call then immediate return
    step(3'd2, 32'd0, 32'h20);
    step(3'd3, 32'd0, 32'h200);
    step(3'd4, 32'd0, 32'd0);
    idle(1'b0);
    // overflow and underflow of the return stack, then flush
    for (int i = 0; i < 5; i++) step(3'd3, 32'd0, 32'h1000 + 32'(i) * 32'h100);
    for (int i = 0; i < 5; i++) step(3'd4, 32'd0, 32'd0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    // wrap past all-ones
    step(3'd2, 32'd0, 32'hFFFF_FFFC);
    step(3'd0, 32'd0, 32'd0);
    idle(1'b0);
    // stall freezes, flush still acts while stalled, reset mid-stall
    step(3'd3, 32'd0, 32'h300);
    drive(1'b1, PCU, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b1, PCU, 3'd4, 32'd0, 32'd0, 1'b1, 1'b1);
    drive(1'b1, PCU, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, PCU, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b1, PCU, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(3'd0, 32'd0, 32'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 5);
      c   = (sel == 5) ? $urandom() : conds[sel];
      if ($urandom_range(0, 99) == 0) begin
        drive(1'b0, IDLE, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      end else begin
        drive(1'b1,
              ($urandom_range(0, 9) < 7) ? PCU : 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)),
              c,
              $urandom() & 32'hFFFF_FFFC,
              ($urandom_range(0, 99) < 15),
              ($urandom_range(0, 99) < 4));
      end
    end
    idle(1'b0);

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
